// File: rtl/banco_de_registradores.sv
// MIPS general-purpose register file: 32 x 32, two combinational read ports,
// one synchronous write port, $zero hardwired, saturating commit counter.
module banco_de_registradores #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter bit                    BYPASS     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h00003FFC,
  parameter logic [DATA_WIDTH-1:0] GP_RESET   = 32'h00001800
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [15:0]           writeCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // entry 0 is never stored; it is decoded to zero on the read side
  logic [DATA_WIDTH-1:0] mem_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] mem_d [1:DEPTH-1];
  logic [15:0]           write_count_q;
  logic [15:0]           write_count_d;
  logic                  write_en;

  function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
    if (idx == 28)      return GP_RESET;
    else if (idx == 29) return SP_RESET;
    else                return '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    if (idx == '0)
      return '0;
    else if (BYPASS && regWrite && reset && (writeReg == idx))
      return writeData;
    else
      return mem_q[idx];
  endfunction

  assign write_en = regWrite && (writeReg != '0);

  always_comb begin
    mem_d = mem_q;
    write_count_d = write_count_q;
    if (write_en) begin
      mem_d[writeReg] = writeData;
      if (write_count_q != 16'hFFFF)
        write_count_d = write_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < DEPTH; i++)
        mem_q[i] <= reset_value(i);
      write_count_q <= '0;
    end else begin
      mem_q         <= mem_d;
      write_count_q <= write_count_d;
    end
  end

  assign readData1  = read_port(readReg1);
  assign readData2  = read_port(readReg2);
  assign writeCount = write_count_q;

endmodule

// File: tb/tb_banco_de_registradores.sv
// Directed bench for banco_de_registradores; one write-through and one
// stored-value instance share the same stimulus.
module tb_banco_de_registradores;

  logic        clock;
  logic        reset;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [15:0] wc_b, wc_n;

  int n_vec = 0;
  int n_err = 0;

  banco_de_registradores #(.BYPASS(1'b1)) u_byp (
    .clock(clock), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .readData1(rd1_b), .readData2(rd2_b), .writeCount(wc_b)
  );

  banco_de_registradores #(.BYPASS(1'b0)) u_nob (
    .clock(clock), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .readData1(rd1_n), .readData2(rd2_n), .writeCount(wc_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_reset(input int idx);
    if (idx == 28)      return 32'h00001800;
    else if (idx == 29) return 32'h00003FFC;
    else                return 32'h0;
  endfunction

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    @(negedge clock);
    regWrite = 1'b1; writeReg = r; writeData = d;
    @(posedge clock); #1;
    regWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;

    // reset state on both ports of both instances
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) begin
      readReg1 = i[4:0]; readReg2 = 5'(31 - i);
      #1;
      check($sformatf("rst_b_p1_r%0d", i), rd1_b, exp_reset(i));
      check($sformatf("rst_b_p2_r%0d", 31 - i), rd2_b, exp_reset(31 - i));
      check($sformatf("rst_n_p1_r%0d", i), rd1_n, exp_reset(i));
    end
    check("rst_wc_b", {16'h0, wc_b}, 32'h0);
    check("rst_wc_n", {16'h0, wc_n}, 32'h0);

    @(negedge clock);
    reset = 1'b1;

    // basic write/read
    write_reg(5'd8, 32'hDEADBEEF);
    readReg1 = 5'd8; readReg2 = 5'd8;
    #1;
    check("wr8_p1_b", rd1_b, 32'hDEADBEEF);
    check("wr8_p2_b", rd2_b, 32'hDEADBEEF);
    check("wr8_p1_n", rd1_n, 32'hDEADBEEF);
    check("wr8_p2_n", rd2_n, 32'hDEADBEEF);
    check("wr8_wc", {16'h0, wc_b}, 32'd1);

    // $zero protection
    @(negedge clock);
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF; readReg1 = 5'd0;
    #1;
    check("zero_pre_b", rd1_b, 32'h0);
    @(posedge clock); #1;
    regWrite = 1'b0;
    #1;
    check("zero_post_b", rd1_b, 32'h0);
    check("zero_post_n", rd1_n, 32'h0);
    check("zero_wc", {16'h0, wc_b}, 32'd1);

    // write-through versus stored value
    write_reg(5'd9, 32'hAAAA5555);
    @(negedge clock);
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h12345678;
    readReg1 = 5'd8; readReg2 = 5'd9;
    #1;
    check("byp_pre_b", rd2_b, 32'h12345678);
    check("byp_pre_n", rd2_n, 32'hAAAA5555);
    check("byp_other_port", rd1_b, 32'hDEADBEEF);
    @(posedge clock); #1;
    check("byp_post_b", rd2_b, 32'h12345678);
    check("byp_post_n", rd2_n, 32'h12345678);
    check("byp_wc", {16'h0, wc_n}, 32'd3);
    regWrite = 1'b0;

    // asynchronous reset between edges
    write_reg(5'd29, 32'h00000001);
    readReg1 = 5'd29; readReg2 = 5'd8;
    #1;
    check("sp_written", rd1_b, 32'h00000001);
    check("sp_wc", {16'h0, wc_b}, 32'd4);
    regWrite = 1'b1; writeReg = 5'd8; writeData = 32'h00000055;
    #1;
    reset = 1'b0;
    #1;
    check("async_sp_b", rd1_b, 32'h00003FFC);
    check("async_sp_n", rd1_n, 32'h00003FFC);
    check("async_r8_nobyp", rd2_b, 32'h0);
    check("async_wc", {16'h0, wc_b}, 32'd0);
    @(posedge clock); #1;
    check("rst_wr_r8_b", rd2_b, 32'h0);
    check("rst_wr_r8_n", rd2_n, 32'h0);
    check("rst_wr_wc", {16'h0, wc_n}, 32'd0);

    // release mid-cycle with a write pending
    @(negedge clock);
    writeReg = 5'd10; writeData = 32'hCAFEF00D; readReg1 = 5'd10;
    #2;
    reset = 1'b1;
    @(posedge clock); #1;
    regWrite = 1'b0;
    #1;
    check("rel_r10_n", rd1_n, 32'hCAFEF00D);
    check("rel_wc", {16'h0, wc_n}, 32'd1);

    // counter saturation
    @(negedge clock);
    regWrite = 1'b1; writeReg = 5'd1; writeData = 32'h1;
    repeat (16'hFFFD) @(posedge clock);
    #1;
    check("sat_fffe", {16'h0, wc_b}, 32'h0000FFFE);
    @(posedge clock); #1;
    check("sat_ffff", {16'h0, wc_b}, 32'h0000FFFF);
    repeat (2) @(posedge clock);
    #1;
    check("sat_hold_b", {16'h0, wc_b}, 32'h0000FFFF);
    check("sat_hold_n", {16'h0, wc_n}, 32'h0000FFFF);
    regWrite = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
